// File: rtl/sd_timer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_timer_scheduler_if
// Purpose  : Avalon-MM write port plus interrupt line of the 16-bit-register
//            interval timer (s1), shared between the scheduler and the timer.
// Signals  : tmr_address    [2:0]  register index (0 status, 1 control,
//                                  2 period low, 3 period high)
//            tmr_chipselect        timer select
//            tmr_write_n           active-low write strobe
//            tmr_writedata  [15:0] write data
//            tmr_irq               timer interrupt (timeout AND ITO)
// Modports : master = scheduler side, slave = timer side
// Revision : 1.0  initial release
// ============================================================================
interface sd_timer_scheduler_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;

  modport master (
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata,
    input  tmr_irq
  );

  modport slave (
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata,
    output tmr_irq
  );
endinterface
`default_nettype wire

// File: rtl/sd_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sd_timer_scheduler
// Purpose  : Shares one Avalon interval timer among NUM_REQ requesters that
//            each want a one-shot delay. Round-robin arbitration, programs
//            the timer (stop, period low/high, clear, start one-shot with
//            ITO), waits for irq, acknowledges it, pulses the owner's done.
// Ports    : clk                          sole clock
//            reset_n                      synchronous active-low reset
//            req        [NUM_REQ-1:0]     level request, held until done
//            req_period [32*NUM_REQ-1:0]  delay per requester, sampled at grant
//            done       [NUM_REQ-1:0]     one-cycle pulse on expiry
//            busy                         high from grant to completion
//            grant_id   [ID_W-1:0]        current or last owner
//            tmr                          timer bus (master modport)
// Revision : 1.0  initial release
// ============================================================================
module sd_timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_period,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  sd_timer_scheduler_if.master   tmr
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ARB     = 4'd1,
    S_W_STOP  = 4'd2,
    S_W_PL    = 4'd3,
    S_W_PH    = 4'd4,
    S_W_CLR   = 4'd5,
    S_W_START = 4'd6,
    S_WAIT    = 4'd7,
    S_ACK     = 4'd8,
    S_DONE    = 4'd9,
    S_CANCEL  = 4'd10
  } state_t;

  localparam logic [15:0] C_CTRL_STOP  = 16'h0008;
  localparam logic [15:0] C_CTRL_START = 16'h0005;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic [31:0]         r_load;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_busy;
  logic [2:0]          r_addr;
  logic                r_cs;
  logic                r_wn;
  logic [15:0]         r_wdata;

  logic                w_found;
  logic [ID_W-1:0]     w_pick;
  logic [ID_W-1:0]     w_cand;
  logic [31:0]         w_period;
  logic [31:0]         w_load;
  logic [ID_W-1:0]     w_owner;
  logic [NUM_REQ-1:0]  w_done_vec;
  logic [2:0]          w_addr;
  logic                w_cs;
  logic                w_wn;
  logic [15:0]         w_wdata;

  // (a + b) mod NUM_REQ, valid for a < NUM_REQ and b <= NUM_REQ
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin pick: first asserted req scanning upward from r_rr_ptr
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = wrap_add(r_rr_ptr, i);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_period = req_period[w_pick*32 +: 32];
  assign w_load   = w_period - 32'd1;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (|req) w_next = S_ARB;
      S_ARB: begin
        // req may have vanished between IDLE and ARB; nothing to grant then
        if (!w_found)                w_next = S_IDLE;
        else if (w_period < 32'd2)   w_next = S_DONE;
        else                         w_next = S_W_STOP;
      end
      S_W_STOP:  w_next = S_W_PL;
      S_W_PL:    w_next = S_W_PH;
      S_W_PH:    w_next = S_W_CLR;
      S_W_CLR:   w_next = S_W_START;
      S_W_START: w_next = S_WAIT;
      S_WAIT: begin
        // irq has priority over a simultaneous req drop
        if (tmr.tmr_irq)              w_next = S_ACK;
        else if (!req[r_grant_id])    w_next = S_CANCEL;
      end
      S_ACK:     w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      S_CANCEL:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so every bus
  // value lines up with the cycle its state is occupied.
  always_comb begin
    w_cs    = 1'b0;
    w_wn    = 1'b1;
    w_addr  = 3'd0;
    w_wdata = 16'h0000;
    case (w_next)
      S_W_STOP:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1; w_wdata = C_CTRL_STOP;    end
      S_W_PL:    begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd2; w_wdata = r_load[15:0];   end
      S_W_PH:    begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd3; w_wdata = r_load[31:16];  end
      S_W_CLR:   begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd0; w_wdata = 16'h0000;       end
      S_W_START: begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1; w_wdata = C_CTRL_START;   end
      S_ACK:     begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd0; w_wdata = 16'h0000;       end
      S_CANCEL:  begin w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1; w_wdata = C_CTRL_STOP;    end
      default:   ;
    endcase
  end

  // On the fast path DONE follows ARB directly, before grant_id is loaded
  assign w_owner = (r_state == S_ARB) ? w_pick : r_grant_id;

  always_comb begin
    w_done_vec          = '0;
    w_done_vec[w_owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_load     <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_cs       <= 1'b0;
      r_wn       <= 1'b1;
      r_addr     <= 3'd0;
      r_wdata    <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_ARB && w_found) begin
        r_grant_id <= w_pick;
        r_load     <= w_load;
        r_rr_ptr   <= wrap_add(w_pick, 1);
      end
      r_done  <= (w_next == S_DONE) ? w_done_vec : '0;
      r_busy  <= (w_next != S_IDLE);
      r_cs    <= w_cs;
      r_wn    <= w_wn;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  assign done               = r_done;
  assign busy               = r_busy;
  assign grant_id           = r_grant_id;
  assign tmr.tmr_address    = r_addr;
  assign tmr.tmr_chipselect = r_cs;
  assign tmr.tmr_write_n    = r_wn;
  assign tmr.tmr_writedata  = r_wdata;

endmodule
`default_nettype wire
